// File: rtl/vga_stream_out.sv
// vga_stream_out: panel timing plus RGB from a show-ahead FIFO; vga_* registered 1 cycle after the counters, fifo_read/frame_start combinational.
// No backpressure upstream: an empty FIFO in the active area blanks the rest of the frame and resyncs at frame_start; VGA_TEST_PATTERN_EN adds WAIT_FILL colour bars.
module vga_stream_out #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic [23:0] fifo_rdata,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_read,
  output logic        streaming,
  output logic        frame_start,
  output logic        underrun,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_DISP  = HW'(HDISP);
  localparam logic [HW-1:0] HS_BEG  = HW'(HDISP + HFP);
  localparam logic [HW-1:0] HS_END  = HW'(HDISP + HFP + HPULSE - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_DISP  = VW'(VDISP);
  localparam logic [VW-1:0] VS_BEG  = VW'(VDISP + VFP);
  localparam logic [VW-1:0] VS_END  = VW'(VDISP + VFP + VPULSE - 1);

  typedef enum logic {WAIT_FILL = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          underrun_q, underrun_d;
  logic          active;
  logic          run_now;
  logic          underrun_evt;

  assign active      = (hcnt_q < H_DISP) && (vcnt_q < V_DISP);
  assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Bar k starts at ceil(k*HDISP/8), so hcnt*8/HDISP needs only constant compares.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= HW'((k * HDISP + 7) / 8)) bar_idx = 3'(k);
    end
  end
`endif

  // State register
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) state_q <= WAIT_FILL;
    else              state_q <= state_d;
  end

  // Next state: fill check only at frame_start, underrun drops back immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FILL: if (frame_start && fifo_full && !(active && fifo_empty)) state_d = RUN;
      RUN:       if (underrun_evt) state_d = WAIT_FILL;
      default:   state_d = WAIT_FILL;
    endcase
  end

  // Outputs: a frame_start that enters RUN already streams its first pixel
  always_comb begin
    run_now      = (state_q == RUN) || (frame_start && fifo_full);
    fifo_read    = active && run_now && !fifo_empty;
    underrun_evt = active && run_now && fifo_empty;
    underrun_d   = underrun_q || underrun_evt;
    hs_d         = !((hcnt_q >= HS_BEG) && (hcnt_q <= HS_END));
    vs_d         = !((vcnt_q >= VS_BEG) && (vcnt_q <= VS_END));
    blank_n_d    = active;
    rgb_d        = '0;
    if (fifo_read) begin
      rgb_d = fifo_rdata;
    end
`ifdef VGA_TEST_PATTERN_EN
    else if (active && !run_now) begin
      rgb_d = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
    end
`endif
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
      rgb_q      <= rgb_d;
      underrun_q <= underrun_d;
    end
  end

  assign streaming            = (state_q == RUN);
  assign underrun             = underrun_q;
  assign vga_hs               = hs_q;
  assign vga_vs               = vs_q;
  assign vga_blank_n          = blank_n_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a 14x8 raster: a queue-backed FIFO and a cycle-indexed model derived from
// the raster arithmetic predict every output; directed phases cover timing, start-up, underrun, reset, late fill.
module tb_vga_stream_out;
  localparam int HD = 8, HF = 2, HP = 3, HB = 1;
  localparam int VD = 4, VF = 1, VP = 2, VB = 1;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FR = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic [23:0] fifo_rdata = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_full = 1'b0;
  logic        fifo_read, streaming, frame_start, underrun;
  logic        vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_stream_out #(
    .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_read(fifo_read), .streaming(streaming), .frame_start(frame_start),
    .underrun(underrun), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int failures = 0;
  logic [23:0] q[$];
  int  t;
  bit  m_run, m_und;
  bit  full_flag, force_empty;
  int  pops, hs_low, vs_low, blank_cnt, rgb_nz, prev_fs, fs_period;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hs"}, vga_hs, 1);
    chk({tag, "_vs"}, vga_vs, 1);
    chk({tag, "_blank"}, vga_blank_n, 0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_stream"}, streaming, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_fs"}, frame_start, 1);
  endtask

  task automatic clear_stats();
    pops = 0; hs_low = 0; vs_low = 0; blank_cnt = 0; rgb_nz = 0;
  endtask

  task automatic refill(input int n);
    while (q.size() < n) q.push_back(24'($urandom));
  endtask

  // One pixel clock: drive FIFO, predict from raster position, check comb then registered outputs.
  task automatic cycle();
    int h, v;
    bit act, fs, run_now, und, exp_rd, rd_obs, exp_hs, exp_vs;
    logic [23:0] exp_rgb;
    logic [2:0]  idx;
    h = t % HT;
    v = (t / HT) % VT;
    act = (h < HD) && (v < VD);
    fs  = (h == 0) && (v == 0);
    fifo_full  = full_flag;
    fifo_empty = force_empty || (q.size() == 0);
    fifo_rdata = fifo_empty ? 24'($urandom) : q[0];
    #1;
    run_now = m_run || (fs && full_flag);
    und     = run_now && act && fifo_empty;
    exp_rd  = run_now && act && !fifo_empty;
    exp_rgb = exp_rd ? q[0] : 24'h0;
    idx = 3'((h * 8) / HD);
`ifdef VGA_TEST_PATTERN_EN
    if (act && !run_now) exp_rgb = {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
`endif
    exp_hs = !((h >= HD + HF) && (h < HD + HF + HP));
    exp_vs = !((v >= VD + VF) && (v < VD + VF + VP));
    if (und) m_und = 1'b1;
    m_run = run_now && !und;
    chk("frame_start", frame_start, fs);
    chk("fifo_read", fifo_read, exp_rd);
    rd_obs = fifo_read;
    if (fs) begin
      if (prev_fs >= 0) fs_period = t - prev_fs;
      prev_fs = t;
    end
    @(posedge pixel_clk);
    if (rd_obs && q.size() != 0) begin
      void'(q.pop_front());
      pops++;
    end
    @(negedge pixel_clk);
    chk("vga_hs", vga_hs, exp_hs);
    chk("vga_vs", vga_vs, exp_vs);
    chk("vga_blank_n", vga_blank_n, act);
    chk("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
    chk("streaming", streaming, m_run);
    chk("underrun", underrun, m_und);
    if (!vga_hs) hs_low++;
    if (!vga_vs) vs_low++;
    if (vga_blank_n) blank_cnt++;
    if ({vga_r, vga_g, vga_b} != 24'h0) rgb_nz++;
    t++;
  endtask

  task automatic release_reset();
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    t = 0; m_run = 1'b0; m_und = 1'b0; prev_fs = -1; fs_period = 0;
  endtask

  initial begin
    full_flag = 1'b0; force_empty = 1'b0;
    t = 0; m_run = 1'b0; m_und = 1'b0; prev_fs = -1; fs_period = 0;
    clear_stats();
    repeat (2) @(negedge pixel_clk);
    check_reset("rst0");
    release_reset();

    // Timing with the FIFO held empty
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      repeat (FR) cycle();
      chk("tim_hs_low", hs_low, 3 * VT);
      chk("tim_vs_low", vs_low, 2 * HT);
      chk("tim_blank", blank_cnt, HD * VD);
      chk("tim_pops", pops, 0);
`ifndef VGA_TEST_PATTERN_EN
      chk("tim_rgb_nz", rgb_nz, 0);
`endif
    end
    chk("tim_fs_period", fs_period, 112);

    // Start-up from a pre-filled FIFO
    for (int i = 1; i <= 64; i++) q.push_back(24'(i));
    full_flag = 1'b1;
    clear_stats();
    cycle();
    chk("su_stream_rise", streaming, 1);
    chk("su_first_px", {vga_r, vga_g, vga_b}, 24'h000001);
    repeat (FR - 1) cycle();
    chk("su_pops0", pops, 32);
    clear_stats();
    repeat (FR) cycle();
    chk("su_pops1", pops, 32);

    // Underrun at the 3rd active pixel of line 1
    refill(64);
    clear_stats();
    for (int i = 0; i < FR; i++) begin
      force_empty = (i == HT + 2);
      cycle();
    end
    force_empty = 1'b0;
    chk("ur_pops", pops, HD + 2);
    chk("ur_sticky", underrun, 1);
    chk("ur_stream", streaming, 0);
    clear_stats();
    cycle();
    chk("ur_rerun", streaming, 1);
    repeat (FR - 1) cycle();
    chk("ur_pops_next", pops, 32);
    chk("ur_still", underrun, 1);

    // Randomised frames: data, fill flag and empty bursts
    for (int i = 0; i < 3 * FR; i++) begin
      refill(40);
      full_flag   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 39) == 0);
      cycle();
    end
    force_empty = 1'b0;

    // Reset mid-frame at hcnt=6, vcnt=2
    full_flag = 1'b1;
    for (int i = 0; i < FR && (t % FR) != (2 * HT + 6); i++) cycle();
    chk("rst_pos_fs", frame_start, 0);
    full_flag = 1'b0; fifo_full = 1'b0;
    pixel_rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (3) @(posedge pixel_clk);
    release_reset();
    cycle();
    chk("rst_after_und", underrun, 0);

    // Late fill: fifo_full rises mid line 0 after a reset
    pixel_rst_n = 1'b0;
    repeat (2) @(posedge pixel_clk);
    release_reset();
    refill(64);
    clear_stats();
    for (int i = 0; i < FR; i++) begin
      if (i == 5) full_flag = 1'b1;
      cycle();
    end
    chk("lf_nopop", pops, 0);
    chk("lf_stream0", streaming, 0);
    clear_stats();
    cycle();
    chk("lf_run", streaming, 1);
    repeat (FR - 1) cycle();
    chk("lf_pops", pops, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
